chaotic_iter_sched: RTL and testbench
=====================================

Name: chaotic_iter_sched

Overview:
Parametrised iteration scheduler for the time-multiplexed chaotic equation core. It owns seeding of the state RAM and round-robin slot addressing for the parameter ROM and state RAM, and runs a bounded number of rounds under start/stop control. It writes core results back to RAM and forwards them through a buffered valid/ready output stream. It sits between the parameter ROM / state RAM and the downstream consumer, with the equation core alongside.

Parameters:
DATA_WIDTH, 64, width of one state variable (x, y or z)
NUM_SLOTS, 243, slots per round; must be >= core latency + 2
ADDR_W, 8, ROM/RAM address width; 2^ADDR_W >= NUM_SLOTS
ROUND_W, 32, width of round counters
OUT_DEPTH, 16, output FIFO depth (power of 2)
DECIM, 4, decimation factor; used only with CHAOTIC_OUT_DECIM_EN

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle start pulse
stop  in  1  one-cycle early-stop request
n_rounds  in  ROUND_W  rounds to run, sampled on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle completion pulse
seed_valid  in  1  seed word valid
seed_ready  out  1  seed word accepted
seed_data  in  3*DATA_WIDTH  {x,y,z} seed
rd_addr  out  ADDR_W  shared ROM/RAM read address
core_in_valid  out  1  core operands valid
core_out_valid  in  1  core result valid
core_out_data  in  3*DATA_WIDTH  {xn1,yn1,zn1}
ram_we  out  1  state RAM write enable
ram_waddr  out  ADDR_W  state RAM write address
ram_wdata  out  3*DATA_WIDTH  state RAM write data
out_valid  out  1  output stream valid
out_ready  in  1  output stream ready
out_data  out  3*DATA_WIDTH  result word
out_slot  out  ADDR_W  slot index of out_data
overrun  out  1  sticky: result dropped because FIFO full
unexpected  out  1  sticky: core_out_valid outside RUN/DRAIN

Behaviour:
- Reset: all outputs 0, FSM IDLE, FIFO empty, counters 0.
- FSM states: IDLE, SEED, RUN, DRAIN.
- IDLE:
  - start with n_rounds = 0 -> done pulses next cycle, stay IDLE.
  - start with n_rounds != 0 -> SEED, busy = 1.
  - start while busy is ignored.
- SEED:
  - seed_ready = 1.
  - Each seed_valid & seed_ready writes ram_waddr = seed index (0..NUM_SLOTS-1), ram_wdata = seed_data, same cycle.
  - After index NUM_SLOTS-1 -> RUN, with read and write slots at 0.
- RUN:
  - rd_addr increments every cycle and wraps NUM_SLOTS-1 -> 0.
  - core_in_valid is rd_addr issue delayed 1 cycle (1-cycle ROM/RAM read latency).
  - Issue round counter increments on each wrap. Issuing stops after the last slot of round n_rounds, or at the next wrap after stop. stop in any other state is ignored.
  - When issuing stops -> DRAIN.
- Write-back (RUN and DRAIN):
  - Each core_out_valid writes core_out_data to the RAM at a write-slot counter that wraps like rd_addr.
  - The same word is pushed to the FIFO with out_slot = write slot.
  - An in-flight counter increments on core_in_valid and decrements on core_out_valid; a simultaneous inc/dec leaves it unchanged.
- DRAIN: when in-flight = 0 -> done pulse, busy = 0, IDLE.
- FIFO:
  - Standard first-word-fall-through; out_valid = !empty; pop on out_valid & out_ready.
  - A push when full drops the word and sets overrun. The RAM write still occurs; the core is never stalled.
  - Simultaneous push and pop when full: pop first, push accepted.
- Sticky flags: overrun and unexpected clear only on reset or accepted start.
- A mid-operation reset aborts immediately and discards FIFO contents.

Optional Feature:
- Macro: CHAOTIC_OUT_DECIM_EN.
- Defined: only results from write rounds r with r % DECIM == 0 (r starts at 0) enter the FIFO. The RAM write-back is unchanged.
- Undefined: every result enters the FIFO and DECIM is unused.

Decomposition:
- Package chaotic_pkg holds:
  - FSM state enum.
  - State word typedef: 3*DATA_WIDTH packed {x,y,z}.
  - Field-slicing constants.
- One sub-module, chaotic_out_fifo: parametrised FWFT FIFO providing full/empty flags.

Test Plan:
- NUM_SLOTS=4, core latency 2, n_rounds=3, seeds 1..4, out_ready=1 -> 12 results in slot order 0,1,2,3 repeated; done exactly once; busy 0 afterward; in-flight returns to 0.
- start with n_rounds=0 -> done pulse one cycle later; no RAM writes; busy stays 0.
- n_rounds=100, stop in round 2 -> issuing halts at the end of round 2; exactly 12 results; done after the last write-back.
- out_ready=0, OUT_DEPTH=4, 2 rounds -> 4 words held; overrun=1; RAM receives all 8 writes; raising out_ready yields slots 0,1,2,3 of round 0.
- seed_valid withheld 5 cycles in SEED -> no ram_we and rd_addr idle; RUN begins only after the 4th seed accepted.
- rst_n asserted mid-RUN -> all outputs 0 next edge; a new start replays from SEED.

Source files
------------

// File: rtl/chaotic_pkg.sv
// Shared types and constants for the chaotic iteration scheduler.
// A state word is a packed {x,y,z} triple; the field helpers locate each variable.
package chaotic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEED,
        ST_RUN,
        ST_DRAIN
    } sched_state_e;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int NUM_FIELDS     = 3;
    localparam int FIELD_X        = 2;
    localparam int FIELD_Y        = 1;
    localparam int FIELD_Z        = 0;

    typedef logic [NUM_FIELDS*DATA_WIDTH_DEF-1:0] state_word_t;

    // LSB position of a field within a packed {x,y,z} word.
    function automatic int field_lsb(input int field, input int dw);
        return field * dw;
    endfunction

endpackage

// File: rtl/chaotic_out_fifo.sv
// First-word-fall-through FIFO for scheduler results; DEPTH must be a power of 2, >= 2.
// A pop on a full FIFO frees the slot that a same-cycle push then fills.
module chaotic_out_fifo
    import chaotic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/chaotic_iter_sched.sv
// Iteration scheduler: seeds state RAM, issues round-robin slots, writes back and streams results.
// Optional CHAOTIC_OUT_DECIM_EN: only write rounds r with r % DECIM == 0 enter the output FIFO.
module chaotic_iter_sched
    import chaotic_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_SLOTS  = 243,
    parameter int ADDR_W     = 8,
    parameter int ROUND_W    = 32,
    parameter int OUT_DEPTH  = 16,
    parameter int DECIM      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic [ROUND_W-1:0]      n_rounds,
    output logic                    busy,
    output logic                    done,
    input  logic                    seed_valid,
    output logic                    seed_ready,
    input  logic [3*DATA_WIDTH-1:0] seed_data,
    output logic [ADDR_W-1:0]       rd_addr,
    output logic                    core_in_valid,
    input  logic                    core_out_valid,
    input  logic [3*DATA_WIDTH-1:0] core_out_data,
    output logic                    ram_we,
    output logic [ADDR_W-1:0]       ram_waddr,
    output logic [3*DATA_WIDTH-1:0] ram_wdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3*DATA_WIDTH-1:0] out_data,
    output logic [ADDR_W-1:0]       out_slot,
    output logic                    overrun,
    output logic                    unexpected
);

    localparam int W  = NUM_FIELDS * DATA_WIDTH;
    localparam int FW = ADDR_W + W;
    localparam int IW = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(NUM_SLOTS - 1);
`ifdef CHAOTIC_OUT_DECIM_EN
    localparam bit DECIM_ON = 1'b1;
`else
    localparam bit DECIM_ON = 1'b0;
`endif

    sched_state_e       state_q, state_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               civ_q, civ_d, stop_req_q, stop_req_d;
    logic               overrun_q, overrun_d, unexpected_q, unexpected_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d, seed_idx_q, seed_idx_d, wr_slot_q, wr_slot_d;
    logic [ROUND_W-1:0] n_rounds_q, n_rounds_d, issue_round_q, issue_round_d;
    logic [ROUND_W-1:0] wr_round_q, wr_round_d;
    logic [IW-1:0]      inflight_q, inflight_d;

    logic start_acc, seed_fire, seed_last, wb_active, wb_fire;
    logic issue_wrap, issue_end, drain_done, keep_round;
    logic fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FW-1:0] fifo_dout;

    assign start_acc  = start && (state_q == ST_IDLE);
    assign seed_fire  = seed_valid && (state_q == ST_SEED);
    assign seed_last  = seed_fire && (seed_idx_q == LAST_SLOT);
    assign wb_active  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign wb_fire    = wb_active && core_out_valid;
    assign issue_wrap = (state_q == ST_RUN) && (rd_addr_q == LAST_SLOT);
    assign issue_end  = issue_wrap &&
                        ((issue_round_q + ROUND_W'(1) == n_rounds_q) || stop_req_q || stop);
    // The operand issued in the last RUN cycle is still counted one cycle into DRAIN.
    assign drain_done = (state_q == ST_DRAIN) && (inflight_q == '0) && !civ_q;
    assign keep_round = !DECIM_ON || ((wr_round_q % ROUND_W'(DECIM)) == '0);
    assign fifo_push  = wb_fire && keep_round;
    assign fifo_pop   = !fifo_empty && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            civ_q         <= 1'b0;
            stop_req_q    <= 1'b0;
            overrun_q     <= 1'b0;
            unexpected_q  <= 1'b0;
            rd_addr_q     <= '0;
            seed_idx_q    <= '0;
            wr_slot_q     <= '0;
            n_rounds_q    <= '0;
            issue_round_q <= '0;
            wr_round_q    <= '0;
            inflight_q    <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            civ_q         <= civ_d;
            stop_req_q    <= stop_req_d;
            overrun_q     <= overrun_d;
            unexpected_q  <= unexpected_d;
            rd_addr_q     <= rd_addr_d;
            seed_idx_q    <= seed_idx_d;
            wr_slot_q     <= wr_slot_d;
            n_rounds_q    <= n_rounds_d;
            issue_round_q <= issue_round_d;
            wr_round_q    <= wr_round_d;
            inflight_q    <= inflight_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start && (n_rounds != '0)) state_d = ST_SEED;
            ST_SEED:  if (seed_last)  state_d = ST_RUN;
            ST_RUN:   if (issue_end)  state_d = ST_DRAIN;
            ST_DRAIN: if (drain_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_d        = busy_q;
        done_d        = 1'b0;
        civ_d         = (state_q == ST_RUN);
        stop_req_d    = stop_req_q;
        overrun_d     = overrun_q;
        unexpected_d  = unexpected_q;
        rd_addr_d     = rd_addr_q;
        seed_idx_d    = seed_idx_q;
        wr_slot_d     = wr_slot_q;
        n_rounds_d    = n_rounds_q;
        issue_round_d = issue_round_q;
        wr_round_d    = wr_round_q;
        inflight_d    = inflight_q;

        if (seed_fire) seed_idx_d = seed_last ? '0 : seed_idx_q + ADDR_W'(1);
        if (state_q == ST_RUN) begin
            rd_addr_d = issue_wrap ? '0 : rd_addr_q + ADDR_W'(1);
            if (issue_wrap) issue_round_d = issue_round_q + ROUND_W'(1);
            if (stop) stop_req_d = 1'b1;
        end
        if (wb_fire) begin
            wr_slot_d = (wr_slot_q == LAST_SLOT) ? '0 : wr_slot_q + ADDR_W'(1);
            if (wr_slot_q == LAST_SLOT) wr_round_d = wr_round_q + ROUND_W'(1);
        end
        if (civ_q && !wb_fire)      inflight_d = inflight_q + IW'(1);
        else if (!civ_q && wb_fire) inflight_d = inflight_q - IW'(1);
        if (core_out_valid && !wb_active)       unexpected_d = 1'b1;
        if (fifo_push && fifo_full && !fifo_pop) overrun_d   = 1'b1;
        if (drain_done) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
        // An accepted start rearms everything, including the sticky flags.
        if (start_acc) begin
            n_rounds_d    = n_rounds;
            stop_req_d    = 1'b0;
            overrun_d     = 1'b0;
            unexpected_d  = 1'b0;
            rd_addr_d     = '0;
            seed_idx_d    = '0;
            wr_slot_d     = '0;
            issue_round_d = '0;
            wr_round_d    = '0;
            if (n_rounds == '0) done_d = 1'b1;
            else                busy_d = 1'b1;
        end
    end

    always_comb begin
        seed_ready    = (state_q == ST_SEED);
        ram_we        = seed_fire || wb_fire;
        ram_waddr     = '0;
        ram_wdata     = '0;
        if (seed_fire) begin
            ram_waddr = seed_idx_q;
            ram_wdata = seed_data;
        end else if (wb_fire) begin
            ram_waddr = wr_slot_q;
            ram_wdata = core_out_data;
        end
        busy          = busy_q;
        done          = done_q;
        rd_addr       = rd_addr_q;
        core_in_valid = civ_q;
        overrun       = overrun_q;
        unexpected    = unexpected_q;
        out_valid     = !fifo_empty;
    end

    assign {out_slot, out_data} = fifo_dout;

    chaotic_out_fifo #(
        .WIDTH (FW),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   ({wr_slot_q, core_out_data}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_chaotic_iter_sched.sv
// Bench for chaotic_iter_sched: environment RAM and a 2-cycle "add 1 per field" core,
// a table of run cases plus hand sequences, results checked against a scoreboard queue.
module tb_chaotic_iter_sched;
    import chaotic_pkg::*;

    localparam int DW = 16;
    localparam int NS = 4;
    localparam int AW = 2;
    localparam int RW = 8;
    localparam int OD = 4;
    localparam int W  = NUM_FIELDS * DW;

    logic          clk = 1'b0;
    logic          rst_n, start, stop, seed_valid, out_ready, inj_v;
    logic [RW-1:0] n_rounds;
    logic [W-1:0]  seed_data, core_out_data, ram_wdata, out_data;
    logic          busy, done, seed_ready, core_in_valid, core_out_valid, ram_we;
    logic          out_valid, overrun, unexpected;
    logic [AW-1:0] rd_addr, ram_waddr, out_slot;

    chaotic_iter_sched #(
        .DATA_WIDTH(DW), .NUM_SLOTS(NS), .ADDR_W(AW), .ROUND_W(RW), .OUT_DEPTH(OD), .DECIM(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .n_rounds(n_rounds),
        .busy(busy), .done(done), .seed_valid(seed_valid), .seed_ready(seed_ready),
        .seed_data(seed_data), .rd_addr(rd_addr), .core_in_valid(core_in_valid),
        .core_out_valid(core_out_valid), .core_out_data(core_out_data), .ram_we(ram_we),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_slot(out_slot),
        .overrun(overrun), .unexpected(unexpected)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk_word(input int a);
        logic [W-1:0] w;
        w = '0;
        w[field_lsb(FIELD_X, DW) +: DW] = DW'(a);
        w[field_lsb(FIELD_Y, DW) +: DW] = DW'(a + 100);
        w[field_lsb(FIELD_Z, DW) +: DW] = DW'(a + 200);
        return w;
    endfunction

    function automatic logic [W-1:0] inc3(input logic [W-1:0] v);
        logic [W-1:0] w;
        for (int f = 0; f < NUM_FIELDS; f++) w[f*DW +: DW] = v[f*DW +: DW] + DW'(1);
        return w;
    endfunction

    // Environment: state RAM with 1-cycle read, 2-stage core.
    logic [W-1:0] ram [NS];
    logic [W-1:0] ram_rdata, p1_d, core_d;
    logic         p1_v, core_v;
    always @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= ram_wdata;
        ram_rdata <= ram[rd_addr];
        if (!rst_n) begin
            p1_v   <= 1'b0;
            core_v <= 1'b0;
        end else begin
            p1_v   <= core_in_valid;
            p1_d   <= inc3(ram_rdata);
            core_v <= p1_v;
            core_d <= p1_d;
        end
    end
    assign core_out_valid = core_v | inj_v;
    assign core_out_data  = core_d;

    typedef struct packed {
        logic [AW-1:0] slot;
        logic [W-1:0]  data;
    } exp_t;
    exp_t sb[$];

    int checks = 0, errors = 0;
    int done_cnt = 0, seed_wr_cnt = 0, wb_cnt = 0, res_cnt = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (ram_we && seed_ready) seed_wr_cnt++;
            if (ram_we && !seed_ready) wb_cnt++;
            if (out_valid && out_ready) begin
                exp_t e;
                res_cnt++;
                if (sb.size() == 0) check("sb_unexpected_word", {out_slot, out_data}, 0);
                else begin
                    e = sb.pop_front();
                    check("out_slot", 64'(out_slot), 64'(e.slot));
                    check("out_data", 64'(out_data), 64'(e.data));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        n_rounds = RW'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic do_seed(input int base);
        for (int s = 0; s < NS; s++) begin
            int g = 0;
            while (!seed_ready && g < 50) begin tick(); g++; end
            check("seed_ready_timeout", seed_ready, 1);
            seed_valid = 1'b1;
            seed_data  = mk_word(base + s);
            tick();
        end
        seed_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && c < budget) begin tick(); c++; end
        check("done_timeout", c < budget, 1);
    endtask

    task automatic push_exp(input int base, input int rounds);
        exp_t e;
        for (int r = 0; r < rounds; r++)
            for (int s = 0; s < NS; s++) begin
                e.slot = AW'(s);
                e.data = mk_word(base + s + r + 1);
                sb.push_back(e);
            end
    endtask

    typedef struct {
        int n;
        int stop_at;
        int base;
        int exp_res;
    } vec_t;
    vec_t cases[5];

    initial begin
        int r0, w0, s0, d0;
        cases[0] = '{n: 3,   stop_at: -1, base: 1,  exp_res: 12};
        cases[1] = '{n: 1,   stop_at: -1, base: 50, exp_res: 4};
        cases[2] = '{n: 100, stop_at: 9,  base: 7,  exp_res: 12};
        cases[3] = '{n: 100, stop_at: 5,  base: 20, exp_res: 8};
        cases[4] = '{n: 2,   stop_at: -1, base: 90, exp_res: 8};

        rst_n = 1'b0; start = 0; stop = 0; seed_valid = 0; out_ready = 1; inj_v = 0;
        n_rounds = '0; seed_data = '0;
        repeat (2) tick();
        check("reset_outs", {busy, done, seed_ready, core_in_valid, ram_we, out_valid,
                             overrun, unexpected, rd_addr}, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            r0 = res_cnt; w0 = wb_cnt; s0 = seed_wr_cnt; d0 = done_cnt;
            push_exp(cases[i].base, cases[i].exp_res / NS);
            do_start(cases[i].n);
            check("busy_after_start", busy, 1);
            do_seed(cases[i].base);
            if (cases[i].stop_at >= 0) begin
                repeat (cases[i].stop_at) tick();
                stop = 1'b1;
                tick();
                stop = 1'b0;
            end
            wait_done(500);
            repeat (8) tick();
            check("result_count", res_cnt - r0, cases[i].exp_res);
            check("writeback_count", wb_cnt - w0, cases[i].exp_res);
            check("seed_writes", seed_wr_cnt - s0, NS);
            check("done_once", done_cnt - d0, 1);
            check("busy_idle", busy, 0);
            check("inflight_zero", dut.inflight_q, 0);
            check("sb_drained", sb.size(), 0);
            check("flags_clear", {overrun, unexpected, out_valid}, 0);
        end

        // Output held off: first round fills the FIFO, second round overruns.
        out_ready = 1'b0;
        r0 = res_cnt; w0 = wb_cnt;
        push_exp(30, 1);
        do_start(2);
        do_seed(30);
        wait_done(500);
        repeat (4) tick();
        check("overrun_set", overrun, 1);
        check("overrun_ram_writes", wb_cnt - w0, 2 * NS);
        check("held_out_valid", out_valid, 1);
        check("held_no_pop", res_cnt - r0, 0);
        out_ready = 1'b1;
        repeat (8) tick();
        check("held_results", res_cnt - r0, OD);
        check("held_sb_drained", sb.size(), 0);

        // Zero rounds: done next cycle, nothing written, start clears overrun.
        s0 = seed_wr_cnt; w0 = wb_cnt; d0 = done_cnt;
        do_start(0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_overrun_cleared", overrun, 0);
        tick();
        check("zero_done_pulse", done, 0);
        repeat (3) tick();
        check("zero_no_writes", (seed_wr_cnt - s0) + (wb_cnt - w0), 0);
        check("zero_done_once", done_cnt - d0, 1);

        // Stray core result while idle.
        inj_v = 1'b1;
        tick();
        inj_v = 1'b0;
        check("unexpected_set", unexpected, 1);
        check("unexpected_no_push", out_valid, 0);

        // Seed stream withheld for 5 cycles.
        r0 = res_cnt; s0 = seed_wr_cnt;
        push_exp(60, 1);
        do_start(1);
        check("start_clears_unexpected", unexpected, 0);
        for (int c = 0; c < 5; c++) check("withhold_idle", {seed_ready, ram_we, rd_addr}, 4'b1000);
        repeat (5) tick();
        for (int s = 0; s < NS; s++) begin
            check("seed_still_open", {seed_ready, rd_addr, core_in_valid}, 4'b1000);
            seed_valid = 1'b1;
            seed_data  = mk_word(60 + s);
            tick();
        end
        seed_valid = 1'b0;
        check("run_entered", {seed_ready, rd_addr}, 0);
        tick();
        check("run_rd_addr_step", rd_addr, 1);
        wait_done(500);
        repeat (8) tick();
        check("withhold_seed_writes", seed_wr_cnt - s0, NS);
        check("withhold_results", res_cnt - r0, NS);

        // Reset in the middle of RUN discards everything; a new start replays from SEED.
        out_ready = 1'b0;
        do_start(3);
        do_seed(70);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("midreset_outs", {busy, done, seed_ready, core_in_valid, ram_we, out_valid,
                                overrun, unexpected, rd_addr}, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        r0 = res_cnt; d0 = done_cnt;
        push_exp(80, 1);
        do_start(1);
        check("replay_seed", seed_ready, 1);
        do_seed(80);
        wait_done(500);
        repeat (8) tick();
        check("replay_results", res_cnt - r0, NS);
        check("replay_done_once", done_cnt - d0, 1);
        check("replay_sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
